// File: rtl/c17_stim_pkg.sv
// Shared types and constants for the c17 stimulus generator.
package c17_stim_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, WAIT, DONE} state_t;
   typedef enum logic {MODE_TOGGLE, MODE_VECTOR} mode_t;

   localparam logic [15:0] LFSR_TAPS = 16'hB400;

   localparam int IDX_N1 = 0;
   localparam int IDX_N2 = 1;
   localparam int IDX_N3 = 2;
   localparam int IDX_N6 = 3;
   localparam int IDX_N7 = 4;
endpackage

// File: rtl/c17_stim_lfsr.sv
// Right-shifting Galois LFSR with step enable and synchronous seed load.
// An all-zero seed would lock the register, so it is replaced by 1.
module c17_stim_lfsr
   import c17_stim_pkg::*;
#(
   parameter int            W     = 16,
   parameter logic [W-1:0]  SEED  = 16'hACE1,
   parameter int            OUT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             step,
   input  logic             load,
   input  logic [W-1:0]     seed,
   output logic [OUT_W-1:0] low_bits
);
   localparam logic [W-1:0] RST_VAL = (SEED == '0) ? W'(1) : SEED;

   logic [W-1:0] value;
   logic [W-1:0] stepped;

   assign stepped  = {1'b0, value[W-1:1]} ^ (value[0] ? W'(LFSR_TAPS) : '0);
   assign low_bits = value[OUT_W-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= RST_VAL;
      end else if (load) begin
         value <= (seed == '0) ? W'(1) : seed;
      end else if (step) begin
         value <= stepped;
      end
   end
endmodule

// File: rtl/c17_stimulus_gen.sv
// Pseudo-random stimulus source for the five c17 primary inputs (N1,N2,N3,N6,N7),
// emitting a programmable number of events separated by random gaps.
module c17_stimulus_gen
   import c17_stim_pkg::*;
#(
   parameter int                N_IN   = 5,
   parameter int                LFSR_W = 16,
   parameter logic [LFSR_W-1:0] SEED   = 16'hACE1,
   parameter int                GAP_W  = 8,
   parameter int                CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic              cfg_mode,
   input  logic [CNT_W-1:0]  cfg_num_events,
   input  logic [GAP_W-1:0]  cfg_min_gap,
   input  logic [GAP_W-1:0]  cfg_gap_mask,
   input  logic              seed_load,
   input  logic [LFSR_W-1:0] seed_i,
   output logic [N_IN-1:0]   stim_o,
   output logic              stim_valid,
   output logic              busy,
   output logic              done,
   output logic [CNT_W-1:0]  event_cnt
);
   state_t             state, next_state;
   mode_t              mode_q;
   logic [CNT_W-1:0]   num_q;
   logic [GAP_W-1:0]   min_gap_q, mask_q, gap_cnt;
   logic [GAP_W-1:0]   lfsr_low, gap_min, gap_msk, gap;
   logic [GAP_W:0]     gap_sum;
   logic               lfsr_step, lfsr_load;
   logic               expire, fire, last_event;
   logic [2:0]         idx_raw, idx;
   logic [N_IN-1:0]    toggle_vec, rand_vec, next_stim;

   c17_stim_lfsr #(
      .W     (LFSR_W),
      .SEED  (SEED),
      .OUT_W (GAP_W)
   ) u_lfsr (
      .clk      (clk),
      .rst_n    (rst_n),
      .step     (lfsr_step),
      .load     (lfsr_load),
      .seed     (seed_i),
      .low_bits (lfsr_low)
   );

   // In LOAD the latched config is not yet valid, so g0 comes straight from cfg_*.
   always_comb begin
      gap_min = (state == LOAD) ? cfg_min_gap  : min_gap_q;
      gap_msk = (state == LOAD) ? cfg_gap_mask : mask_q;
      gap_sum = {1'b0, gap_min} + {1'b0, lfsr_low & gap_msk};
      gap     = gap_sum[GAP_W] ? '1 : gap_sum[GAP_W-1:0];
   end

   always_comb begin
      expire     = (state == WAIT) && (gap_cnt == '0);
      fire       = expire && !stop;
      last_event = ({1'b0, event_cnt} + (CNT_W+1)'(1)) == {1'b0, num_q};
      idx_raw    = lfsr_low[2:0];
      idx        = (idx_raw >= 3'(N_IN)) ? idx_raw - 3'(N_IN) : idx_raw;
      toggle_vec = stim_o ^ (N_IN'(1) << idx);
      rand_vec   = lfsr_low[N_IN-1:0];
      if (rand_vec == stim_o) begin
         rand_vec = rand_vec ^ (N_IN'(1) << IDX_N1);
      end
      next_stim  = (mode_q == MODE_VECTOR) ? rand_vec : toggle_vec;
   end

   always_comb begin
      next_state = state;
      lfsr_step  = 1'b0;
      lfsr_load  = 1'b0;
      case (state)
         IDLE: begin
            if (seed_load) begin
               lfsr_load = 1'b1;
            end else if (start) begin
               next_state = LOAD;
            end
         end
         LOAD: begin
            lfsr_step = 1'b1;
            if (stop) begin
               next_state = IDLE;
            end else if (cfg_num_events == '0) begin
               next_state = DONE;
            end else begin
               next_state = WAIT;
            end
         end
         WAIT: begin
            lfsr_step = 1'b1;
            if (stop) begin
               next_state = IDLE;
            end else if (expire && last_event) begin
               next_state = DONE;
            end
         end
         DONE: begin
            if (stop) begin
               next_state = IDLE;
            end else if (start) begin
               next_state = LOAD;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stim_o     <= '0;
         stim_valid <= 1'b0;
         event_cnt  <= '0;
         gap_cnt    <= '0;
         mode_q     <= MODE_TOGGLE;
         num_q      <= '0;
         min_gap_q  <= '0;
         mask_q     <= '0;
      end else begin
         stim_valid <= fire;
         if (state == LOAD && !stop) begin
            mode_q    <= mode_t'(cfg_mode);
            num_q     <= cfg_num_events;
            min_gap_q <= cfg_min_gap;
            mask_q    <= cfg_gap_mask;
            event_cnt <= '0;
            gap_cnt   <= gap;
         end
         if (fire) begin
            stim_o    <= next_stim;
            event_cnt <= event_cnt + CNT_W'(1);
            gap_cnt   <= gap;
         end else if (state == WAIT && !expire) begin
            gap_cnt <= gap_cnt - GAP_W'(1);
         end
      end
   end

   assign busy = (state == LOAD) || (state == WAIT);
   assign done = (state == DONE);
endmodule

// File: tb/tb_c17_stimulus_gen.sv
// Bench for c17_stimulus_gen: directed run table plus randomized runs against an event-level model.
module tb_c17_stimulus_gen;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        start, stop, cfg_mode, seed_load;
   logic [15:0] cfg_num_events, seed_i, event_cnt;
   logic [7:0]  cfg_min_gap, cfg_gap_mask;
   logic [4:0]  stim_o;
   logic        stim_valid, busy, done;

   int n_pass  = 0;
   int n_total = 0;

   logic [15:0] m_lfsr;
   logic [4:0]  m_stim;
   int          m_cnt;

   typedef struct {
      bit mode;
      int n;
      int mg;
      int mk;
      int stop_evt;   // 0: run to completion, k: stop on expiry of event k
      int first;      // expected first change offset, -1 if not fixed
      int spacing;    // >0 exact spacing, -1 saturated-gap range, 0 no check
      int fin;        // expected final event_cnt
   } run_t;

   run_t tbl[5];

   always #5 clk = ~clk;

   c17_stimulus_gen dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start),
      .stop           (stop),
      .cfg_mode       (cfg_mode),
      .cfg_num_events (cfg_num_events),
      .cfg_min_gap    (cfg_min_gap),
      .cfg_gap_mask   (cfg_gap_mask),
      .seed_load      (seed_load),
      .seed_i         (seed_i),
      .stim_o         (stim_o),
      .stim_valid     (stim_valid),
      .busy           (busy),
      .done           (done),
      .event_cnt      (event_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [15:0] lstep(input logic [15:0] x);
      return (x >> 1) ^ (x[0] ? 16'hB400 : 16'h0000);
   endfunction

   function automatic logic [15:0] lpow(input logic [15:0] x, input int n);
      logic [15:0] y = x;
      for (int i = 0; i < n; i++) y = lstep(y);
      return y;
   endfunction

   function automatic int gap_of(input logic [15:0] l, input int mg, input int mk);
      int s = mg + (int'(l[7:0]) & mk);
      return (s > 255) ? 255 : s;
   endfunction

   function automatic logic [4:0] upd(input bit mode, input logic [15:0] l, input logic [4:0] s);
      logic [4:0] v;
      if (!mode) begin
         v = s;
         v[int'(l[2:0]) % 5] = ~v[int'(l[2:0]) % 5];
      end else begin
         v = l[4:0];
         if (v == s) v = v ^ 5'b00001;
      end
      return v;
   endfunction

   task automatic run(input run_t r);
      logic [15:0] v, l0;
      logic [4:0]  s, s0, prev, exp_s;
      int          eq[$];
      logic [4:0]  sq[$];
      int          obs[$];
      int          nxt, done_edge, e_stop, last_k, cnt0, nev, lim, g;
      bit          stopped;

      l0 = m_lfsr; s0 = m_stim; cnt0 = m_cnt;
      v = l0; s = s0; done_edge = 1; e_stop = 0;
      // Event schedule: LOAD cycle sees l0, the cycle before edge m sees l0 stepped m-1 times.
      if (r.n > 0) begin
         nxt = gap_of(v, r.mg, r.mk) + 2;
         for (int m = 1; m < 60000; m++) begin
            if (m == nxt) begin
               s = upd(r.mode, v, s);
               eq.push_back(m);
               sq.push_back(s);
               if (eq.size() == r.n) begin
                  done_edge = m;
                  break;
               end
               nxt = m + gap_of(v, r.mg, r.mk) + 1;
            end
            v = lstep(v);
         end
      end
      if (r.stop_evt > 0) begin
         e_stop = eq[r.stop_evt-1];
         while (eq.size() > r.stop_evt - 1) begin
            void'(eq.pop_back());
            void'(sq.pop_back());
         end
         done_edge = 1 << 30;
         last_k = e_stop;
      end else begin
         last_k = done_edge + 2;
      end
      lim = (r.stop_evt > 0) ? e_stop : done_edge;

      cfg_mode       = r.mode;
      cfg_num_events = 16'(r.n);
      cfg_min_gap    = 8'(r.mg);
      cfg_gap_mask   = 8'(r.mk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      prev = s0;
      for (int k = 0; k <= last_k; k++) begin
         if (k > 0) @(negedge clk);
         nev = 0;
         foreach (eq[i]) if (eq[i] <= k) nev++;
         exp_s   = (nev > 0) ? sq[nev-1] : s0;
         stopped = (r.stop_evt > 0) && (k == e_stop);
         chk("stim_o", stim_o, exp_s);
         chk("stim_valid", stim_valid, (nev > 0) ? (eq[nev-1] == k) : 1'b0);
         chk("event_cnt", event_cnt, (k == 0) ? cnt0 : nev);
         chk("done", done, !stopped && k >= done_edge);
         chk("busy", busy, !stopped && k < done_edge);
         if (stim_o !== prev) obs.push_back(k);
         if (stim_valid === 1'b1) begin
            if (!r.mode) chk("one_bit_change", $countones(stim_o ^ prev), 1);
            else         chk("vector_differs", ($countones(stim_o ^ prev) >= 1), 1);
         end
         prev = stim_o;
         if (k >= 1 && !stopped) begin
            cfg_mode       = 1'($urandom);
            cfg_num_events = 16'($urandom);
            cfg_min_gap    = 8'($urandom);
            cfg_gap_mask   = 8'($urandom);
         end
         start = (k >= 1 && k < lim && $urandom_range(0, 5) == 0);
         stop  = (r.stop_evt > 0 && k == e_stop - 1);
      end
      start = 1'b0;
      stop  = 1'b0;

      chk("final_cnt", event_cnt, r.fin);
      chk("n_changes", obs.size(), r.fin);
      if (r.first >= 0 && obs.size() > 0) chk("first_edge", obs[0], r.first);
      for (int i = 0; i < obs.size(); i++) begin
         if (r.spacing > 0 && i > 0) chk("spacing", obs[i] - obs[i-1], r.spacing);
         if (r.spacing == -1) begin
            g = (i == 0) ? obs[0] - 2 : obs[i] - obs[i-1] - 1;
            chk("sat_gap_range", (g >= 240 && g <= 255), 1);
         end
      end

      m_stim = (sq.size() > 0) ? sq[sq.size()-1] : s0;
      m_cnt  = sq.size();
      m_lfsr = lpow(l0, (r.stop_evt > 0) ? e_stop : done_edge);
   endtask

   initial begin
      run_t rr;
      tbl[0] = '{1'b0, 4,  3,     0,     0, 5,  4, 4};
      tbl[1] = '{1'b1, 10, 0,     0,     0, 2,  1, 10};
      tbl[2] = '{1'b0, 0,  2,     3,     0, -1, 0, 0};
      tbl[3] = '{1'b1, 3,  8'hF0, 8'hFF, 0, -1, -1, 3};
      tbl[4] = '{1'b0, 5,  2,     0,     3, 4,  3, 2};

      m_lfsr = 16'hACE1; m_stim = '0; m_cnt = 0;
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; seed_load = 1'b0; seed_i = '0;
      cfg_mode = 1'b0; cfg_num_events = '0; cfg_min_gap = '0; cfg_gap_mask = '0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(negedge clk);
      chk("rst_stim_o", stim_o, 0);
      chk("rst_stim_valid", stim_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_event_cnt", event_cnt, 0);
      chk("rst_lfsr", dut.u_lfsr.value, 16'hACE1);

      foreach (tbl[i]) run(tbl[i]);

      // seed_load beats start in IDLE; a zero seed becomes 1 and holds while idle
      seed_load = 1'b1; seed_i = 16'h0000; start = 1'b1;
      @(negedge clk);
      seed_load = 1'b0; start = 1'b0;
      chk("seed_prio_busy", busy, 0);
      chk("zero_seed_lfsr", dut.u_lfsr.value, 16'h0001);
      repeat (3) @(negedge clk);
      chk("idle_lfsr_hold", dut.u_lfsr.value, 16'h0001);
      m_lfsr = 16'h0001;

      for (int i = 0; i < 8; i++) begin
         rr.mode     = 1'($urandom);
         rr.n        = $urandom_range(1, 6);
         rr.mg       = $urandom_range(0, 4);
         rr.mk       = $urandom_range(0, 15);
         rr.stop_evt = ($urandom_range(0, 3) == 0) ? $urandom_range(1, rr.n) : 0;
         rr.first    = -1;
         rr.spacing  = 0;
         rr.fin      = (rr.stop_evt > 0) ? rr.stop_evt - 1 : rr.n;
         run(rr);
      end
      rr = '{1'b1, 3, 1, 2, 0, -1, 0, 3};
      run(rr);

      // stop from DONE returns to IDLE with outputs held
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
      chk("stop_done_busy", busy, 0);
      chk("stop_done_done", done, 0);
      chk("stop_done_stim", stim_o, m_stim);
      chk("stop_done_cnt", event_cnt, m_cnt);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
